// File: rtl/peak_depth_out.sv
// Peak-to-depth stage: combines window base and fine peak bin into a ToF bin,
// scales it to millimetres with a shift-add multiplier and queues results.
module peak_depth_out #(
  parameter int NB = 5,
  parameter int NP = 10,
  parameter int MW = 8,
  parameter logic [MW-1:0] BIN_MM = MW'(15),
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          peakDone,
  input  logic [NB-1:0] peakCH,
  input  logic [NB-1:0] peakFH,
  input  logic [NP-1:0] THminus,
  input  logic          depthReady,
  output logic          depthValid,
  output logic [NP+MW:0] depthData,
  output logic          depthHit,
  output logic [7:0]    depthSeq,
  output logic          busy,
  output logic          overrun,
  output logic          dropped
);
  localparam int AW = NP + 1 + MW;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SUM, MUL, PUSH} state_t;

  typedef struct packed {
    logic          hit;
    logic [7:0]    seq;
    logic [AW-1:0] data;
  } entry_t;

  state_t        state;
  logic          pdd;
  logic          hit;
  logic [NB-1:0] fh_q;
  logic [NP-1:0] th_q;
  logic [NP:0]   tof;
  logic [AW-1:0] acc;
  logic [AW-1:0] addend;
  logic [CW-1:0] mcnt;
  logic [7:0]    seq;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic evt;
  logic full;
  logic pop;
  logic wr_en;

  assign evt    = peakDone & ~pdd;
  assign busy   = (state != IDLE);
  assign full   = (count == (PW+1)'(FIFO_DEPTH));
  assign pop    = depthValid & depthReady;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign wr_en  = (state == PUSH) & (~full | pop);
  assign addend = BIN_MM[mcnt] ? (AW'(tof) << mcnt) : '0;

  assign depthValid = (count != '0);
  assign depthHit   = mem[rd_ptr].hit;
  assign depthSeq   = mem[rd_ptr].seq;
  assign depthData  = mem[rd_ptr].data;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      pdd     <= 1'b0;
      hit     <= 1'b0;
      fh_q    <= '0;
      th_q    <= '0;
      tof     <= '0;
      acc     <= '0;
      mcnt    <= '0;
      seq     <= '0;
      overrun <= 1'b0;
      dropped <= 1'b0;
    end else begin
      pdd <= peakDone;
      if (evt && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (evt) begin
            hit   <= |peakCH;
            fh_q  <= peakFH;
            th_q  <= THminus;
            state <= SUM;
          end
        end
        SUM: begin
          tof   <= hit ? ({1'b0, th_q} + (NP+1)'(fh_q)) : '0;
          acc   <= '0;
          mcnt  <= '0;
          state <= MUL;
        end
        MUL: begin
          acc  <= acc + addend;
          mcnt <= mcnt + CW'(1);
          if (mcnt == CW'(MW - 1))
            state <= PUSH;
        end
        PUSH: begin
          seq <= seq + 8'd1;
          if (!wr_en)
            dropped <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{hit: hit, seq: seq, data: acc};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !pop)
        count <= count + (PW+1)'(1);
      else if (!wr_en && pop)
        count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_peak_depth_out.sv
// Bench for peak_depth_out: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_peak_depth_out;
  logic        clk = 1'b0;
  logic        res;
  logic        peakDone;
  logic [4:0]  peakCH;
  logic [4:0]  peakFH;
  logic [9:0]  THminus;
  logic        depthReady;
  logic        depthValid;
  logic [18:0] depthData;
  logic        depthHit;
  logic [7:0]  depthSeq;
  logic        busy;
  logic        overrun;
  logic        dropped;

  int nvec = 0;
  int nerr = 0;

  peak_depth_out dut (
    .clk(clk), .res(res), .peakDone(peakDone), .peakCH(peakCH),
    .peakFH(peakFH), .THminus(THminus), .depthReady(depthReady),
    .depthValid(depthValid), .depthData(depthData), .depthHit(depthHit),
    .depthSeq(depthSeq), .busy(busy), .overrun(overrun), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results computed as (THminus+peakFH)*15 at event time,
  // appear in the queue 10 cycles later, drained when ready.
  typedef struct {
    int data;
    int hit;
    int seq;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  int   bcnt;
  int   mseq;
  bit   mpdd;
  bit   movr;
  bit   mdrop;

  always @(posedge clk or posedge res) begin
    if (res) begin
      q.delete();
      bcnt  = 0;
      mseq  = 0;
      mpdd  = 0;
      movr  = 0;
      mdrop = 0;
    end else begin
      int n;
      bit do_pop;
      bit ev_m;
      n      = q.size();
      do_pop = (n > 0) && depthReady;
      ev_m   = peakDone && !mpdd;
      mpdd   = peakDone;
      if (bcnt > 0) begin
        if (ev_m) movr = 1;
        bcnt--;
        if (bcnt == 0) begin
          if (n < 4 || do_pop) begin
            pend.seq = mseq;
            q.push_back(pend);
          end else begin
            mdrop = 1;
          end
          mseq = (mseq + 1) % 256;
        end
      end else if (ev_m) begin
        bcnt      = 10;
        pend.hit  = (peakCH != 0) ? 1 : 0;
        pend.data = pend.hit ? (int'(THminus) + int'(peakFH)) * 15 : 0;
      end
      if (do_pop) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!res) begin
      chk("m_valid", depthValid, (q.size() > 0) ? 1 : 0);
      chk("m_busy", busy, (bcnt > 0) ? 1 : 0);
      chk("m_overrun", overrun, movr);
      chk("m_dropped", dropped, mdrop);
      if (q.size() > 0) begin
        chk("m_data", depthData, q[0].data);
        chk("m_hit", depthHit, q[0].hit);
        chk("m_seq", depthSeq, q[0].seq);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    chk("rst_valid", depthValid, 0);
    chk("rst_data", depthData, 0);
    chk("rst_hit", depthHit, 0);
    chk("rst_seq", depthSeq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_drop", dropped, 0);
    res = 1'b0;
  endtask

  task automatic ev(input int th, input int fh, input int ch,
                    output int lat, output int nbusy,
                    output int d, output int h, output int s);
    @(negedge clk);
    THminus  = 10'(th);
    peakFH   = 5'(fh);
    peakCH   = 5'(ch);
    peakDone = 1'b1;
    @(negedge clk);
    peakDone = 1'b0;
    lat = 0; nbusy = 0; d = -1; h = -1; s = -1;
    for (int k = 1; k <= 11; k++) begin
      if (busy) nbusy++;
      if (depthValid && lat == 0) begin
        lat = k;
        d = int'(depthData);
        h = int'(depthHit);
        s = int'(depthSeq);
      end
      if (k < 11) @(negedge clk);
    end
  endtask

  initial begin
    int lat, nb, d, h, s, cnt;
    res = 1'b1; peakDone = 1'b0; peakCH = '0; peakFH = '0;
    THminus = '0; depthReady = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // 1: basic result, latency, busy length
    ev(500, 12, 3, lat, nb, d, h, s);
    chk("t1_latency", lat, 11);
    chk("t1_busy_cycles", nb, 10);
    chk("t1_data", d, 7680);
    chk("t1_hit", h, 1);
    chk("t1_seq", s, 0);

    // 2: maximum operands, then no-target
    do_reset();
    ev(1023, 31, 1, lat, nb, d, h, s);
    chk("t2_data_max", d, 15810);
    chk("t2_seq_a", s, 0);
    ev(1023, 31, 0, lat, nb, d, h, s);
    chk("t2_data_nt", d, 0);
    chk("t2_hit_nt", h, 0);
    chk("t2_seq_b", s, 1);

    // 3: fill with consumer stalled, one drop, then drain in order
    do_reset();
    depthReady = 1'b0;
    ev(100, 0, 1, lat, nb, d, h, s);
    chk("t3_head_data", d, 1500);
    ev(0, 31, 2, lat, nb, d, h, s);
    ev(1023, 0, 5, lat, nb, d, h, s);
    ev(7, 7, 0, lat, nb, d, h, s);
    chk("t3_no_drop_yet", dropped, 0);
    ev(300, 5, 1, lat, nb, d, h, s);
    chk("t3_dropped", dropped, 1);
    @(negedge clk);
    depthReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_pop_valid", depthValid, 1);
      chk("t3_pop_seq", depthSeq, i);
      @(negedge clk);
    end
    chk("t3_empty", depthValid, 0);
    ev(2, 3, 1, lat, nb, d, h, s);
    chk("t3_next_seq", s, 5);
    chk("t3_next_data", d, 75);

    // 4: second edge while busy is ignored
    do_reset();
    depthReady = 1'b0;
    @(negedge clk);
    THminus = 10'd20; peakFH = 5'd3; peakCH = 5'd2; peakDone = 1'b1;
    @(negedge clk);
    peakDone = 1'b0;
    repeat (3) @(negedge clk);
    peakDone = 1'b1;
    @(negedge clk);
    peakDone = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_overrun", overrun, 1);
    chk("t4_valid", depthValid, 1);
    chk("t4_seq", depthSeq, 0);
    chk("t4_data", depthData, 345);
    depthReady = 1'b1;
    @(negedge clk);
    chk("t4_one_entry", depthValid, 0);
    ev(10, 1, 1, lat, nb, d, h, s);
    chk("t4_next_seq", s, 1);
    chk("t4_next_data", d, 165);

    // 5: full queue with a pop coinciding with the push
    do_reset();
    depthReady = 1'b0;
    for (int i = 0; i < 4; i++)
      ev(40 * i, i, 1, lat, nb, d, h, s);
    @(negedge clk);
    THminus = 10'd9; peakFH = 5'd1; peakCH = 5'd4; peakDone = 1'b1;
    @(negedge clk);
    peakDone = 1'b0;
    repeat (9) @(negedge clk);
    depthReady = 1'b1;
    @(negedge clk);
    depthReady = 1'b0;
    chk("t5_dropped", dropped, 0);
    chk("t5_head_seq", depthSeq, 1);
    depthReady = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8 && depthValid; k++) begin
      cnt++;
      if (cnt == 4) begin
        chk("t5_tail_seq", depthSeq, 4);
        chk("t5_tail_data", depthData, 150);
      end
      @(negedge clk);
    end
    chk("t5_occupancy", cnt, 4);

    // 6: reset in the middle of a multiply
    do_reset();
    depthReady = 1'b0;
    ev(5, 5, 1, lat, nb, d, h, s);
    @(negedge clk);
    THminus = 10'd50; peakFH = 5'd2; peakCH = 5'd1; peakDone = 1'b1;
    @(negedge clk);
    peakDone = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    res = 1'b1;
    #1;
    chk("t6_valid", depthValid, 0);
    chk("t6_data", depthData, 0);
    chk("t6_seq", depthSeq, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    res = 1'b0;
    depthReady = 1'b1;
    ev(50, 2, 1, lat, nb, d, h, s);
    chk("t6_after_lat", lat, 11);
    chk("t6_after_seq", s, 0);
    chk("t6_after_data", d, 780);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/peak_depth_out.md
Name: peak_depth_out

Overview:
- Downstream of the peak detector and the algebraic block in the dToF pixel chain.
- On each completed peak search it combines the coarse window base (THminus) with the fine-histogram peak bin (peakFH) into an absolute ToF bin.
- It scales that bin to millimetres with a sequential shift-add multiplier.
- It queues results in a small output FIFO drained by a valid/ready handshake toward readout.

Parameters:
NB, 5, fine-histogram address width (matches `Nb)
NP, 10, coarse/rough data width (matches `Np)
BIN_MM, 15, millimetres per fine bin (unsigned constant)
MW, 8, width of BIN_MM; also the number of multiplier iterations
FIFO_DEPTH, 4, output queue entries (power of two)

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous reset, active-high
peakDone  in  1  peak detector done level; a rising edge marks a new result
peakCH  in  NB  coarse-histogram peak bin; 0 = no target
peakFH  in  NB  fine-histogram peak bin within the window
THminus  in  NP  window lower threshold from the algebraic block
depthReady  in  1  consumer ready
depthValid  out  1  FIFO head valid
depthData  out  NP+1+MW  distance in mm (19 bits at defaults)
depthHit  out  1  1 = target present, 0 = no-target entry
depthSeq  out  8  sequence number of the head entry
busy  out  1  high while not in IDLE
overrun  out  1  sticky: peak edge lost while busy
dropped  out  1  sticky: result discarded because FIFO full

Behaviour:
- Reset (async, res=1): all outputs 0; FSM=IDLE; FIFO empty; seq counter 0; edge-detect register 0. Reset mid-operation aborts any calculation and clears the FIFO and both sticky flags.
- Edge detect: pdd <= peakDone each cycle; event = peakDone & ~pdd.
- IDLE:
  - On event, capture peakCH, peakFH, THminus.
  - hit = (peakCH != 0).
  - Go to SUM.
- SUM (1 cycle):
  - tof = {1'b0,THminus} + peakFH, NP+1 bits, no overflow possible.
  - If !hit, force tof=0.
  - acc=0, mcnt=0.
  - Go to MUL.
- MUL (exactly MW cycles):
  - Iteration i: if BIN_MM[i], acc += tof << i.
  - After iteration MW-1, go to PUSH.
  - acc width NP+1+MW; never wraps.
- PUSH (1 cycle):
  - If FIFO not full, write {hit, seq, acc}; otherwise discard the result and set dropped.
  - seq increments by 1 (mod 256) in both cases.
  - Go to IDLE.
- Fixed latency: an event seen at posedge t is written at posedge t+MW+2. depthValid rises at t+MW+3 if the FIFO was empty (t+11 at defaults).
- Events arriving while busy=1 are ignored, set overrun, and do not consume a sequence number.
- FIFO:
  - Head is presented combinationally from storage.
  - Pop on depthValid & depthReady.
  - Push and pop in the same cycle when full is allowed: the pop frees a slot, so no drop occurs.
  - Pointers wrap modulo FIFO_DEPTH; the count is tracked with an extra bit.
- depthData, depthHit and depthSeq hold stable while depthValid=1 and depthReady=0. Values are undefined-but-stable (last written) when depthValid=0; the bench checks them only when valid.
- Sticky flags clear only on reset.

Test Plan:
1. Reset, then THminus=500, peakFH=12, peakCH=3, pulse peakDone, depthReady=1 -> depthValid at edge+11, depthData=7680, depthHit=1, depthSeq=0, busy high for 10 cycles.
2. THminus=1023, peakFH=31, peakCH=1 -> depthData=15810. Then peakCH=0 with the same other inputs -> depthData=0, depthHit=0, depthSeq=1.
3. depthReady=0 with 5 results spaced 12 cycles apart -> FIFO holds seq 0..3, dropped=1, seq advances to 5. Then raise depthReady -> 4 pops in order 0,1,2,3, after which depthValid=0.
4. Second peakDone rising edge 4 cycles after the first -> overrun=1, exactly one FIFO entry, next accepted result carries seq=1.
5. FIFO full and depthReady=1 in the same cycle as PUSH -> no drop, dropped stays 0, occupancy stays 4.
6. Assert res during the MUL state -> all outputs 0 immediately, FIFO empty. A later event produces seq=0 with the correct result.
